instr_fetch_unit: RTL and testbench

Multi-cycle instruction fetch stage for the lab4 RISC-V CPU. It sits directly upstream of the control FSM and holds the program counter. On each fetch request it performs one instruction-memory read through a ready handshake and latches the 32-bit instruction register. It then presents the instruction and its opcode field to the controller and decoder for the ID state.

---
 rtl/instr_fetch_unit_pkg.sv | 31 +++
 rtl/instr_fetch_unit_timeout_counter.sv | 26 ++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the lab4 instruction fetch stage and the control FSM:
// fetch state encoding, NOP word, opcode width and the RV32I major opcodes.
package instr_fetch_unit_pkg;

    localparam int OPCODE_W  = 7;
    localparam int TIMEOUT_W = 8;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b001_0111;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b010_0011;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b011_0011;
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b011_0111;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b110_0111;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b110_1111;
    localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b111_0011;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_timeout_counter.sv
// WAIT-cycle counter for the fetch stage; expired pulses in the cycle whose
// increment would reach the limit. Instantiated only with FETCH_TIMEOUT_EN.
module fetch_timeout_counter
    import instr_fetch_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg == (limit - 1'b1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage (IDLE -> WAIT -> DONE) holding the PC.
// Define FETCH_TIMEOUT_EN to abort fetches that wait TIMEOUT_CYCLES cycles.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] PC_RESET       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_start,
    input  logic                pc_write,
    input  logic [31:0]         pc_in,
    output logic                i_mem_read,
    output logic [31:0]         i_mem_addr,
    input  logic                i_mem_ready,
    input  logic [31:0]         i_mem_data,
    output logic [31:0]         instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [31:0]         pc,
    output logic                instr_valid,
    output logic                fetch_busy,
    output logic                fetch_err,
    output logic [15:0]         fetch_count
);

    generate
        if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("instr_fetch_unit: TIMEOUT_CYCLES must be within 2..255");
        end
    endgenerate

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic [31:0]  fetch_addr_reg, fetch_addr_next;
    logic [31:0]  instr_reg, instr_next;
    logic         err_reg, err_next;
    logic [15:0]  count_reg, count_next;
    logic         timeout_expired;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    // The counter is held clear outside WAIT, so each fetch starts from zero.
    fetch_timeout_counter u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_reg != WAIT),
        .enable  ((state_reg == WAIT) && !i_mem_ready),
        .limit   (TIMEOUT_LIMIT),
        .expired (timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            pc_reg         <= PC_RESET;
            fetch_addr_reg <= '0;
            instr_reg      <= NOP_INSTR;
            err_reg        <= 1'b0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            fetch_addr_reg <= fetch_addr_next;
            instr_reg      <= instr_next;
            err_reg        <= err_next;
            count_reg      <= count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_write ? pc_in : pc_reg;
        fetch_addr_next = fetch_addr_reg;
        instr_next      = instr_reg;
        err_next        = err_reg;
        count_next      = count_reg;

        case (state_reg)
            IDLE: begin
                // Misaligned requests never reach memory; only the sticky flag records them.
                if (fetch_start) begin
                    if (is_word_aligned(pc_reg)) begin
                        fetch_addr_next = pc_reg;
                        state_next      = WAIT;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            WAIT: begin
                // Ready in the limit cycle wins over the timeout.
                if (i_mem_ready) begin
                    instr_next = i_mem_data;
                    count_next = count_reg + 16'd1;
                    state_next = DONE;
                end else if (timeout_expired) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign i_mem_read  = (state_reg == WAIT);
    assign i_mem_addr  = (state_reg == WAIT) ? fetch_addr_reg : '0;
    assign instr_valid = (state_reg == DONE);
    assign fetch_busy  = (state_reg != IDLE);
    assign instr       = instr_reg;
    assign opcode      = instr_reg[OPCODE_W-1:0];
    assign pc          = pc_reg;
    assign fetch_err   = err_reg;
    assign fetch_count = count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; the timeout section is
// compiled in only when FETCH_TIMEOUT_EN is defined.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic        fetch_start;
    logic        pc_write;
    logic [31:0] pc_in;
    logic        i_mem_read;
    logic [31:0] i_mem_addr;
    logic        i_mem_ready;
    logic [31:0] i_mem_data;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_err;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_count = '0;

    instr_fetch_unit #(
        .PC_RESET       (32'h0000_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_write    (pc_write),
        .pc_in       (pc_in),
        .i_mem_read  (i_mem_read),
        .i_mem_addr  (i_mem_addr),
        .i_mem_ready (i_mem_ready),
        .i_mem_data  (i_mem_data),
        .instr       (instr),
        .opcode      (opcode),
        .pc          (pc),
        .instr_valid (instr_valid),
        .fetch_busy  (fetch_busy),
        .fetch_err   (fetch_err),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        fetch_start = 1'b0;
        pc_write    = 1'b0;
        i_mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        exp_count = '0;
        $display("reset applied");
    endtask

    // Inputs change and outputs are sampled on negedges; ready is given in WAIT cycle n_wait.
    task automatic do_fetch(input int n_wait, input logic [31:0] data, input logic [31:0] exp_addr,
                            input logic pcw, input logic [31:0] pcv);
        int valid_seen;
        valid_seen  = 0;
        fetch_start = 1'b1;
        pc_write    = pcw;
        pc_in       = pcv;
        @(negedge clk);
        fetch_start = 1'b0;
        pc_write    = 1'b0;
        if (pcw) check_eq("pc_after_write", pc, pcv);
        for (int i = 1; i <= n_wait; i++) begin
            check_eq("wait_read", {31'd0, i_mem_read}, 32'd1);
            check_eq("wait_addr", i_mem_addr, exp_addr);
            check_eq("wait_busy", {31'd0, fetch_busy}, 32'd1);
            if (instr_valid) valid_seen++;
            fetch_start = (i == 2);
            if (i == n_wait) begin
                i_mem_ready = 1'b1;
                i_mem_data  = data;
            end
            @(negedge clk);
            fetch_start = 1'b0;
        end
        i_mem_ready = 1'b0;
        i_mem_data  = 32'hFFFF_FFFF;
        exp_count   = exp_count + 16'd1;
        if (instr_valid) valid_seen++;
        check_eq("done_valid", {31'd0, instr_valid}, 32'd1);
        check_eq("done_instr", instr, data);
        check_eq("done_opcode", {25'd0, opcode}, {25'd0, data[6:0]});
        check_eq("done_read", {31'd0, i_mem_read}, 32'd0);
        check_eq("done_count", {16'd0, fetch_count}, {16'd0, exp_count});
        @(negedge clk);
        if (instr_valid) valid_seen++;
        check_eq("valid_pulses", valid_seen, 32'd1);
        check_eq("idle_busy", {31'd0, fetch_busy}, 32'd0);
        check_eq("idle_instr", instr, data);
        $display("fetch addr=%h wait=%0d data=%h count=%0d", exp_addr, n_wait, data, fetch_count);
    endtask

    initial begin
        reset       = 1'b1;
        fetch_start = 1'b0;
        pc_write    = 1'b0;
        pc_in       = '0;
        i_mem_ready = 1'b0;
        i_mem_data  = '0;
        do_reset();

        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_instr", instr, 32'h0000_0013);
        check_eq("rst_read", {31'd0, i_mem_read}, 32'd0);
        check_eq("rst_addr", i_mem_addr, 32'h0);
        check_eq("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("rst_busy", {31'd0, fetch_busy}, 32'd0);
        check_eq("rst_err", {31'd0, fetch_err}, 32'd0);
        check_eq("rst_count", {16'd0, fetch_count}, 32'd0);

        // Single fetch, ready in the second WAIT cycle: instr_valid lands in cycle 3.
        do_fetch(2, 32'h0000_0093, 32'h0, 1'b0, 32'h0);
        check_eq("single_opcode", {25'd0, opcode}, 32'h13);

        // Variable latency with stray fetch_start pulses in WAIT.
        do_fetch(1, 32'h0010_0113, 32'h0, 1'b0, 32'h0);
        do_fetch(4, 32'h0020_81B3, 32'h0, 1'b0, 32'h0);
        do_fetch(9, 32'h0000_006F, 32'h0, 1'b0, 32'h0);
        check_eq("err_still_clear", {31'd0, fetch_err}, 32'd0);

        // pc_write together with fetch_start: old pc fetched, new pc used next.
        do_fetch(1, 32'h0000_0037, 32'h0, 1'b1, 32'h40);
        check_eq("pc_is_40", pc, 32'h40);
        do_fetch(3, 32'h0000_0017, 32'h40, 1'b0, 32'h0);

        // Misaligned PC.
        pc_write = 1'b1;
        pc_in    = 32'h42;
        @(negedge clk);
        pc_write    = 1'b0;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        check_eq("mis_read", {31'd0, i_mem_read}, 32'd0);
        check_eq("mis_busy", {31'd0, fetch_busy}, 32'd0);
        check_eq("mis_err", {31'd0, fetch_err}, 32'd1);
        check_eq("mis_count", {16'd0, fetch_count}, {16'd0, exp_count});
        @(negedge clk);
        check_eq("mis_read2", {31'd0, i_mem_read}, 32'd0);
        check_eq("mis_err_sticky", {31'd0, fetch_err}, 32'd1);
        $display("misaligned fetch at pc=%h err=%0d", pc, fetch_err);

        // Reset in the middle of WAIT, then a late ready.
        do_reset();
        check_eq("rst2_err", {31'd0, fetch_err}, 32'd0);
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        check_eq("midrst_read_before", {31'd0, i_mem_read}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        i_mem_ready = 1'b1;
        i_mem_data  = 32'hDEAD_BEEF;
        check_eq("midrst_read", {31'd0, i_mem_read}, 32'd0);
        check_eq("midrst_instr", instr, 32'h0000_0013);
        @(negedge clk);
        i_mem_ready = 1'b0;
        check_eq("midrst_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("midrst_instr2", instr, 32'h0000_0013);
        check_eq("midrst_busy", {31'd0, fetch_busy}, 32'd0);
        check_eq("midrst_count", {16'd0, fetch_count}, 32'd0);
        $display("reset during WAIT, late ready ignored instr=%h", instr);

`ifdef FETCH_TIMEOUT_EN
        // Memory never ready: 16 WAIT cycles, then abort.
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            check_eq("to_read", {31'd0, i_mem_read}, 32'd1);
            @(negedge clk);
        end
        check_eq("to_read_drop", {31'd0, i_mem_read}, 32'd0);
        check_eq("to_err", {31'd0, fetch_err}, 32'd1);
        check_eq("to_busy", {31'd0, fetch_busy}, 32'd0);
        check_eq("to_valid", {31'd0, instr_valid}, 32'd0);
        check_eq("to_instr", instr, 32'h0000_0013);
        check_eq("to_count", {16'd0, fetch_count}, 32'd0);
        $display("timeout abort err=%0d", fetch_err);

        // Ready in the 16th WAIT cycle completes normally.
        do_reset();
        do_fetch(16, 32'h0000_0073, 32'h0, 1'b0, 32'h0);
        check_eq("to_edge_err", {31'd0, fetch_err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
